// File: rtl/display_pkg.sv
// Shared types and helpers for the 7-segment scan sequencer.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned PWM_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    // One-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [SEL_W-1:0] sel);
        return NUM_DIGITS'(1) << sel;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Slot counter and PWM phase counter. The *_c flags are combinational and
// describe the upcoming cycle (post-edge counter values), so the parent can
// register its outputs in step with the counters; wrap_c describes the
// current cycle.
module slot_timer
    import display_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    output logic             wrap_c,
    output logic             slot_start_c,
    output logic             slot_end_c,
    output logic             in_blank_c,
    output logic [PWM_W-1:0] pwm_nxt_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;

    // Next counter values: restart at slot end or on clear, else advance.
    always_comb begin
        wrap_c = (cnt_q == CW'(DIV - 1));
        cnt_d  = cnt_q + CW'(1);
        pwm_d  = pwm_q + PWM_W'(1);
        if (clr_i || wrap_c) begin
            cnt_d = '0;
            pwm_d = '0;
        end
        slot_start_c = (cnt_d == '0);
        slot_end_c   = (cnt_d == CW'(DIV - 1));
        in_blank_c   = (cnt_d < CW'(BLANK));
        pwm_nxt_c    = pwm_d;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed 4-digit anode scanner with per-slot blanking, PWM
// brightness and per-digit masking. All outputs are registered.
module scan_sequencer
    import display_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PWM_W-1:0]      bright,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  digit_strobe,
    output logic                  frame_done
);

    scan_state_t           state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [PWM_W-1:0]      bright_q, bright_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  strobe_q, strobe_d;
    logic                  frame_q, frame_d;

    logic                  clr;
    logic                  wrap, slot_start, slot_end, in_blank;
    logic [PWM_W-1:0]      pwm_nxt;

    // Counters are held at zero in IDLE and while disabled.
    assign clr = !en || (state_q == ST_IDLE);

    slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .wrap_c       (wrap),
        .slot_start_c (slot_start),
        .slot_end_c   (slot_end),
        .in_blank_c   (in_blank),
        .pwm_nxt_c    (pwm_nxt)
    );

    // Next state, digit select, slot sampling and output values.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        bright_d = bright_q;
        mask_d   = mask_q;
        an_d     = '0;
        strobe_d = 1'b0;
        frame_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            sel_d   = '0;
        end else begin
            if (state_q == ST_IDLE) begin
                sel_d = '0;
            end else if (wrap) begin
                sel_d = sel_q + SEL_W'(1);
            end
            state_d = in_blank ? ST_BLANK : ST_ON;
            if (slot_start) begin
                bright_d = bright;
                mask_d   = digit_en;
            end
            strobe_d = slot_start;
            frame_d  = slot_end && (sel_d == SEL_W'(NUM_DIGITS - 1));
            // ON never coincides with slot start, so the held samples are current.
            if ((state_d == ST_ON) && mask_q[sel_d] && (pwm_nxt <= bright_q)) begin
                an_d = digit_onehot(sel_d);
            end
        end
    end

    // State, sampling and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            bright_q <= '0;
            mask_q   <= '0;
            an_q     <= '0;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            bright_q <= bright_d;
            mask_q   <= mask_d;
            an_q     <= an_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
        end
    end

    assign sel          = sel_q;
    assign an           = an_q;
    assign digit_strobe = strobe_q;
    assign frame_done   = frame_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer with a cycle-count reference model.
module tb_scan_sequencer;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned ND    = 4;
    localparam int unsigned FRAME = ND * DIV;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic [3:0] bright   = 4'd0;
    logic [3:0] digit_en = 4'd0;
    logic [1:0] sel;
    logic [3:0] an;
    logic       digit_strobe;
    logic       frame_done;

    scan_sequencer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .bright       (bright),
        .digit_en     (digit_en),
        .sel          (sel),
        .an           (an),
        .digit_strobe (digit_strobe),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic       strobe;
        logic       frame;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned compared    = 0;
    int unsigned mismatched  = 0;

    // Reference-model state, readable by the stimulus for scenario timing.
    bit          running     = 1'b0;
    int          t_cyc       = 0;
    int          cur_s       = -1;
    int          cur_c       = -1;
    logic [3:0]  b_s         = 4'd0;
    logic [3:0]  m_s         = 4'd0;
    bit          timeout_evt = 1'b0;

    // Reference model: position in the frame is just cycles since enable.
    initial begin : model
        exp_t e;
        int   s;
        int   c;
        forever begin
            @(posedge clk);
            e = '0;
            if (!rst_n) begin
                running = 1'b0;
                b_s     = 4'd0;
                m_s     = 4'd0;
                cur_s   = -1;
                cur_c   = -1;
            end else if (!en) begin
                running = 1'b0;
                cur_s   = -1;
                cur_c   = -1;
            end else begin
                if (!running) begin
                    running = 1'b1;
                    t_cyc   = 0;
                end else begin
                    t_cyc = (t_cyc + 1) % FRAME;
                end
                c = t_cyc % DIV;
                s = t_cyc / DIV;
                if (c == 0) begin
                    b_s = bright;
                    m_s = digit_en;
                end
                e.sel    = 2'(s);
                e.strobe = (c == 0);
                e.frame  = (s == ND - 1) && (c == DIV - 1);
                if ((c >= BLANK) && m_s[s] && ((c % 16) <= int'(b_s)))
                    e.an = 4'(1 << s);
                cur_s = s;
                cur_c = c;
            end
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and checks outputs mid-cycle.
    initial begin : monitor
        exp_t e;
        bit   to_seen;
        to_seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel", int'(sel), int'(e.sel));
                chk("an", int'(an), int'(e.an));
                chk("digit_strobe", int'(digit_strobe), int'(e.strobe));
                chk("frame_done", int'(frame_done), int'(e.frame));
            end
            chk("an_onehot0", int'($onehot0(an)), 1);
            if (!to_seen) begin
                chk("wait_timeout", int'(timeout_evt), 0);
                if (timeout_evt) to_seen = 1'b1;
            end
            #2;
            if (!rst_n) begin
                chk("async_rst_an", int'(an), 0);
                chk("async_rst_sel", int'(sel), 0);
                chk("async_rst_strobe", int'(digit_strobe), 0);
                chk("async_rst_frame", int'(frame_done), 0);
            end
        end
    end

    // Advance n edges, then settle 2 time units past the edge to drive.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait until the model reports the given digit slot and slot count.
    task automatic wait_at(input int s, input int c);
        for (int i = 0; i < 200; i++) begin
            if (running && (cur_s == s) && (cur_c == c)) return;
            tick(1);
        end
        timeout_evt = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin : stim
        rst_n = 1'b0;
        en    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Full brightness, all digits.
        en       = 1'b1;
        bright   = 4'd15;
        digit_en = 4'b1111;
        tick(2 * FRAME);

        // Reduced brightness.
        bright = 4'd3;
        tick(FRAME + DIV);

        // Masked digits 1 and 3.
        bright   = 4'd15;
        digit_en = 4'b0101;
        tick(2 * FRAME);

        // Disable mid-ON of digit 2, then re-enable.
        digit_en = 4'b1111;
        wait_at(2, 4);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(FRAME);

        // Brightness change mid-slot of digit 1.
        wait_at(1, 3);
        bright = 4'd3;
        tick(2 * DIV + 2);
        bright = 4'd15;

        // Disable exactly on the last cycle of a frame.
        wait_at(3, DIV - 1);
        en = 1'b0;
        tick(2);
        en = 1'b1;

        // Asynchronous reset mid-ON of digit 3.
        wait_at(3, 5);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(FRAME + 4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 5) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end

        en = 1'b1;
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
